// File: rtl/unidade_controle_comparador_pkg.sv
// Shared definitions for the comparator control unit: the 4-bit state codes
// (also shown on the 7-segment debug display) and the Moore output decode.
package unidade_controle_comparador_pkg;

    // State codes are fixed because the datapath debug decoder displays them.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    // Moore output decode: outputs depend on the state alone.
    function automatic saidas_t decodifica(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            PREPARA: begin
                s.zera_c = 1'b1;
                s.zera_r = 1'b1;
            end
            REGISTRA:   s.registra_r = 1'b1;
            PROXIMO:    s.conta_c    = 1'b1;
            FIM_ACERTO: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FIM_ERRO: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.errou   = 1'b1;
                s.timeout = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_comparador_contador_timeout.sv
// Modulo-M up counter used as the ESPERA watchdog. 'fim' flags the last
// count (M-1). 'zera' has priority over 'conta'.
module contador_timeout #(
    parameter int unsigned M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);
    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, wrap at M-1, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            if (cnt_q == ULTIMO) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == ULTIMO);

endmodule

// File: rtl/unidade_controle_comparador.sv
// Moore control unit for the counter/comparator datapath: clears it, waits
// for each move, registers the switches, checks 'igual' and advances the
// counter until 'fim' or a mismatch, then holds the verdict.
// Optional macro UNIDADE_CONTROLE_TIMEOUT_EN adds an ESPERA watchdog
// (TIMEOUT_CICLOS cycles) ending in FIM_TIMEOUT; without it ESPERA waits forever.
module unidade_controle_comparador
    import unidade_controle_comparador_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera_c,
    output logic       conta_c,
    output logic       zera_r,
    output logic       registra_r,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);
    // The watchdog counter needs at least two states to be meaningful.
    if (TIMEOUT_CICLOS < 2) begin : g_timeout_invalido
        $error("TIMEOUT_CICLOS must be at least 2");
    end

    estado_t estado_q;
    estado_t estado_d;
    saidas_t saidas_q;
    saidas_t saidas_d;
    logic    em_espera;
    logic    timer_fim;

    assign em_espera = (estado_q == ESPERA);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    // Watchdog runs only in ESPERA and is held clear everywhere else.
    contador_timeout #(
        .M(TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (!em_espera),
        .conta (em_espera),
        .fim   (timer_fim)
    );
`else
    assign timer_fim = 1'b0;
`endif

    // Next-state logic and output decode of the next state, so the outputs
    // can be registered and still match the state register exactly.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:  if (iniciar) estado_d = PREPARA;
            PREPARA:  estado_d = ESPERA;
            ESPERA: begin
                // A move in the expiry cycle wins over the timeout.
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (em_espera && timer_fim) begin
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                    estado_d = FIM_TIMEOUT;
`else
                    estado_d = ESPERA;
`endif
                end
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                // A mismatch takes priority over reaching the last value.
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (fim) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:    estado_d = ESPERA;
            FIM_ACERTO: if (iniciar) estado_d = PREPARA;
            FIM_ERRO:   if (iniciar) estado_d = PREPARA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            FIM_TIMEOUT: if (iniciar) estado_d = PREPARA;
`endif
            default:    estado_d = INICIAL;
        endcase

        saidas_d = decodifica(estado_d);
`ifndef UNIDADE_CONTROLE_TIMEOUT_EN
        saidas_d.timeout = 1'b0;
`endif
    end

    // State and output registers; reset forces INICIAL with all outputs low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            saidas_q <= saidas_d;
        end
    end

    assign zera_c     = saidas_q.zera_c;
    assign conta_c    = saidas_q.conta_c;
    assign zera_r     = saidas_q.zera_r;
    assign registra_r = saidas_q.registra_r;
    assign pronto     = saidas_q.pronto;
    assign acertou    = saidas_q.acertou;
    assign errou      = saidas_q.errou;
    assign timeout    = saidas_q.timeout;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle_comparador.sv
// Directed bench for unidade_controle_comparador with a small behavioural
// datapath counter. Timeout steps build only with UNIDADE_CONTROLE_TIMEOUT_EN.
module tb_unidade_controle_comparador;

    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_PREP = 8'hA0;
    localparam logic [7:0] O_REG  = 8'h10;
    localparam logic [7:0] O_PROX = 8'h40;
    localparam logic [7:0] O_ACE  = 8'h0C;
    localparam logic [7:0] O_ERR  = 8'h0A;
    localparam logic [7:0] O_TO   = 8'h0B;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b1;
    logic       fim;
    logic       zera_c, conta_c, zera_r, registra_r;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [7:0] saidas_obs;

    logic [3:0] cnt;
    logic [3:0] limite = 4'd15;
    int         n_reg = 0;
    int         n_conta = 0;
    int         n_zera = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         base_reg, base_conta, base_zera;

    unidade_controle_comparador #(
        .TIMEOUT_CICLOS(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .jogada     (jogada),
        .igual      (igual),
        .fim        (fim),
        .zera_c     (zera_c),
        .conta_c    (conta_c),
        .zera_r     (zera_r),
        .registra_r (registra_r),
        .pronto     (pronto),
        .acertou    (acertou),
        .errou      (errou),
        .timeout    (timeout),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    assign saidas_obs = {zera_c, conta_c, zera_r, registra_r, pronto, acertou, errou, timeout};
    assign fim = (cnt == limite);

    // Behavioural datapath counter driven by the control outputs.
    always @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (zera_c) cnt <= '0;
        else if (conta_c) cnt <= cnt + 4'd1;
    end

    // Pulse tallies of the control outputs.
    always @(posedge clock) begin
        if (registra_r) n_reg <= n_reg + 1;
        if (conta_c) n_conta <= n_conta + 1;
        if (zera_c) n_zera <= n_zera + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_est(input string tag, input logic [3:0] est, input logic [7:0] outs);
        chk({tag, "_estado"}, 32'(db_estado), 32'(est));
        chk({tag, "_saidas"}, 32'(saidas_obs), 32'(outs));
    endtask

    // One move from ESPERA: leaves the bench just after the COMPARA exit edge.
    task automatic jogar(input logic ig);
        igual  = ig;
        jogada = 1'b1;
        tick();
        chk_est("registra", 4'h4, O_REG);
        jogada = 1'b0;
        tick();
        chk_est("compara", 4'h5, O_NONE);
        tick();
    endtask

    // Start from INICIAL or a final state and land in ESPERA.
    task automatic comecar();
        iniciar = 1'b1;
        tick();
        chk_est("prepara", 4'h1, O_PREP);
        iniciar = 1'b0;
        tick();
        chk_est("espera", 4'h2, O_NONE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk_est("reset", 4'h0, O_NONE);
        tick();
        reset = 1'b0;
        tick();
        chk_est("inicial_ocioso", 4'h0, O_NONE);

        // iniciar pulse, then iniciar held in ESPERA is ignored
        comecar();
        iniciar = 1'b1;
        tick();
        tick();
        chk_est("espera_ignora_iniciar", 4'h2, O_NONE);
        iniciar = 1'b0;

        // 16 matching moves, fim on the 16th
        limite     = 4'd15;
        base_reg   = n_reg;
        base_conta = n_conta;
        for (int i = 0; i < 16; i++) begin
            jogar(1'b1);
            if (i < 15) begin
                chk_est("proximo", 4'h6, O_PROX);
                tick();
                chk_est("espera_loop", 4'h2, O_NONE);
            end
        end
        chk_est("fim_acerto", 4'hA, O_ACE);
        chk("pulsos_registra", 32'(n_reg - base_reg), 32'd16);
        chk("pulsos_conta", 32'(n_conta - base_conta), 32'd15);

        // jogada in a final state is ignored
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        chk_est("acerto_ignora_jogada", 4'hA, O_ACE);

        // Restart from FIM_ACERTO clears the datapath counter
        base_zera = n_zera;
        comecar();
        chk("pulsos_zera", 32'(n_zera - base_zera), 32'd1);
        chk("contador_zerado", 32'(cnt), 32'd0);

        // Mismatch on the 3rd move
        base_conta = n_conta;
        for (int i = 0; i < 3; i++) begin
            jogar(i != 2);
            if (i < 2) begin
                chk_est("proximo_erro", 4'h6, O_PROX);
                // A move offered in PROXIMO is lost
                if (i == 1) jogada = 1'b1;
                tick();
                jogada = 1'b0;
                chk_est("espera_erro", 4'h2, O_NONE);
            end
        end
        chk_est("fim_erro", 4'hE, O_ERR);
        chk("pulsos_conta_erro", 32'(n_conta - base_conta), 32'd2);

        // Mismatch has priority over fim (fim already true at count 0)
        limite = 4'd0;
        comecar();
        jogar(1'b0);
        chk_est("erro_prioridade", 4'hE, O_ERR);

        // Asynchronous reset while in COMPARA
        limite = 4'd15;
        comecar();
        igual  = 1'b1;
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        chk_est("antes_reset", 4'h5, O_NONE);
        #3;
        reset = 1'b1;
        #1;
        chk_est("reset_assincrono", 4'h0, O_NONE);
        tick();
        reset = 1'b0;
        tick();
        chk_est("apos_reset", 4'h0, O_NONE);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        // No move for 16 cycles -> timeout
        comecar();
        for (int i = 0; i < 15; i++) tick();
        chk_est("espera_limite", 4'h2, O_NONE);
        tick();
        chk_est("fim_timeout", 4'hF, O_TO);

        // Move in the expiry cycle wins
        comecar();
        for (int i = 0; i < 15; i++) tick();
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        chk_est("jogada_no_limite", 4'h4, O_REG);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
